pulse_pacer: RTL and testbench



---
 rtl/pulse_pkg.sv | 15 +
 rtl/pulse_pacer_sat_counter.sv | 54 +++++
 rtl/pulse_pacer.sv | 96 +++++++++
 tb/tb_pulse_pacer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pulse_pkg.sv
// Shared types and constants for the pulse pacer.
package pulse_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIRE = 2'd1,
        WAIT = 2'd2
    } pacer_state_t;

    // Smallest pulse spacing the pacer FSM can produce (FIRE then one WAIT cycle).
    function automatic int unsigned min_gap();
        return 2;
    endfunction

endpackage

// File: rtl/pulse_pacer_sat_counter.sv
// Saturating up/down counter with a sticky overflow flag.
// A decrement is only requested when count + inc >= 1, so it never underflows.
module sat_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    input  logic         dec_i,
    input  logic         clr_ovf_i,
    output logic [W-1:0] count_o,
    output logic         ovf_o
);

    localparam logic [W-1:0] MAX = '1;
    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt_q, cnt_d;
    logic         ovf_q, ovf_d;
    logic         drop;

    // Next count and overflow; a set in the same cycle as a clear wins.
    always_comb begin
        cnt_d = cnt_q;
        drop  = 1'b0;
        if (dec_i) begin
            if (!inc_i) begin
                cnt_d = cnt_q - ONE;
            end
        end else if (inc_i) begin
            if (cnt_q == MAX) begin
                drop = 1'b1;
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end
        ovf_d = drop | (ovf_q & ~clr_ovf_i);
    end

    // Count and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign count_o = cnt_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/pulse_pacer.sv
// Event pacer ahead of the CDC pulse synchronizer: queues single-cycle
// requests and re-emits them as single-cycle pulses at least GAP cycles apart.
module pulse_pacer
    import pulse_pkg::*;
#(
    parameter int unsigned CNT_W = 4,
    parameter int unsigned GAP   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in,
    input  logic             clrOvf,
    output logic             out,
    output logic [CNT_W-1:0] pending,
    output logic             busy,
    output logic             overflow
);

    localparam int unsigned WC_W = (GAP > 2) ? $clog2(GAP) : 1;
    localparam logic [WC_W-1:0] WAIT_LOAD = WC_W'(GAP - 2);

    generate
        if (GAP < min_gap() || CNT_W < 1) begin : g_bad_params
            $error("pulse_pacer: GAP must be >= 2 and CNT_W >= 1");
        end
    endgenerate

    pacer_state_t    state_q, state_d;
    logic [WC_W-1:0] wait_q, wait_d;
    logic            out_q, out_d;
    logic            req;
    logic            fire_go;

    assign req     = in || (pending != '0);
    assign fire_go = (state_d == FIRE);

    // State, wait counter and output pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wait_q  <= '0;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            out_q   <= out_d;
        end
    end

    // Next state and wait countdown; the last WAIT cycle can fire directly.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        unique case (state_q)
            IDLE: begin
                if (req) state_d = FIRE;
            end
            FIRE: begin
                state_d = WAIT;
                wait_d  = WAIT_LOAD;
            end
            WAIT: begin
                if (wait_q == '0) begin
                    state_d = req ? FIRE : IDLE;
                end else begin
                    wait_d = wait_q - WC_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                wait_d  = '0;
            end
        endcase
    end

    // Outputs: pulse is registered from the next state, busy decodes registers.
    always_comb begin
        out_d = (state_d == FIRE);
        busy  = (state_q != IDLE) || (pending != '0);
    end

    sat_counter #(
        .W (CNT_W)
    ) u_pending (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc_i     (in),
        .dec_i     (fire_go),
        .clr_ovf_i (clrOvf),
        .count_o   (pending),
        .ovf_o     (overflow)
    );

    assign out = out_q;

endmodule

// File: tb/tb_pulse_pacer.sv
// Scoreboard bench: expected pulse cycles are queued by the stimulus and
// popped by a monitor whenever a pacer emits a pulse.
module tb_pulse_pacer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    int         cyc = 0;

    // Main instance: CNT_W=4, GAP=8.
    logic       in_m = 1'b0, clr_m = 1'b0;
    logic       out_m, busy_m, ovf_m;
    logic [3:0] pend_m;

    // Small instance for saturation: CNT_W=2, GAP=8.
    logic       in_s = 1'b0, clr_s = 1'b0;
    logic       out_s, busy_s, ovf_s;
    logic [1:0] pend_s;

    int exp_m[$];
    int exp_s[$];
    int n_cmp = 0;
    int n_bad = 0;
    int b;

    pulse_pacer #(.CNT_W(4), .GAP(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .in(in_m), .clrOvf(clr_m),
        .out(out_m), .pending(pend_m), .busy(busy_m), .overflow(ovf_m)
    );

    pulse_pacer #(.CNT_W(2), .GAP(8)) u_small (
        .clk(clk), .rst_n(rst_n), .in(in_s), .clrOvf(clr_s),
        .out(out_s), .pending(pend_s), .busy(busy_s), .overflow(ovf_s)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every emitted pulse must match the head of its queue.
    always @(negedge clk) begin
        int e;
        if (out_m) begin
            n_cmp++;
            if (exp_m.size() == 0) begin
                n_bad++;
                $display("FAIL main_pulse: unexpected pulse at cycle %0d", cyc);
            end else begin
                e = exp_m.pop_front();
                if (e != cyc) begin
                    n_bad++;
                    $display("FAIL main_pulse: got pulse at cycle %0d, expected cycle %0d", cyc, e);
                end
            end
        end
        if (out_s) begin
            n_cmp++;
            if (exp_s.size() == 0) begin
                n_bad++;
                $display("FAIL small_pulse: unexpected pulse at cycle %0d", cyc);
            end else begin
                e = exp_s.pop_front();
                if (e != cyc) begin
                    n_bad++;
                    $display("FAIL small_pulse: got pulse at cycle %0d, expected cycle %0d", cyc, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy_m || busy_s) && n < 200) begin
            step();
            n++;
        end
        check("idle_reached", int'(busy_m | busy_s), 0);
        step();
    endtask

    initial begin
        // Reset held with input toggling: everything stays at zero.
        #3 rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_m = i[0];
            in_s = ~i[0];
            step();
            check("rst_out", int'(out_m), 0);
            check("rst_pend", int'(pend_m), 0);
            check("rst_busy", int'(busy_m), 0);
            check("rst_ovf", int'(ovf_m | ovf_s), 0);
        end
        in_m = 1'b0;
        in_s = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("post_rst_out", int'(out_m | out_s), 0);
        end

        // Single event.
        b = cyc;
        in_m = 1'b1; exp_m.push_back(b + 1);
        step(); in_m = 1'b0;
        check("single_pend", int'(pend_m), 0);
        repeat (7) step();
        check("single_busy_hi", int'(busy_m), 1);
        step();
        check("single_busy_lo", int'(busy_m), 0);
        wait_idle();

        // Three-event burst.
        b = cyc;
        in_m = 1'b1;
        exp_m.push_back(b + 1); exp_m.push_back(b + 9); exp_m.push_back(b + 17);
        step();
        step();
        check("burst_pend_c2", int'(pend_m), 1);
        step(); in_m = 1'b0;
        check("burst_pend_c3", int'(pend_m), 2);
        repeat (7) step();
        check("burst_pend_c10", int'(pend_m), 1);
        repeat (8) step();
        check("burst_pend_c18", int'(pend_m), 0);
        wait_idle();

        // Request in the last WAIT cycle with nothing pending.
        b = cyc;
        in_m = 1'b1; exp_m.push_back(b + 1);
        step(); in_m = 1'b0;
        repeat (7) step();
        in_m = 1'b1; exp_m.push_back(b + 9);
        step(); in_m = 1'b0;
        check("lastwait_pend", int'(pend_m), 0);
        wait_idle();

        // Request in a fire-transition cycle with pending = 2.
        b = cyc;
        in_m = 1'b1;
        exp_m.push_back(b + 1); exp_m.push_back(b + 9);
        exp_m.push_back(b + 17); exp_m.push_back(b + 25);
        step();
        step();
        step(); in_m = 1'b0;
        check("firein_pend_c3", int'(pend_m), 2);
        repeat (5) step();
        in_m = 1'b1;
        step(); in_m = 1'b0;
        check("firein_pend_c9", int'(pend_m), 2);
        repeat (8) step();
        check("firein_pend_c17", int'(pend_m), 1);
        repeat (8) step();
        check("firein_pend_c25", int'(pend_m), 0);
        wait_idle();

        // Saturation on the 2-bit instance.
        b = cyc;
        in_s = 1'b1;
        exp_s.push_back(b + 1); exp_s.push_back(b + 9);
        exp_s.push_back(b + 17); exp_s.push_back(b + 25);
        repeat (4) step();
        check("sat_pend_c4", int'(pend_s), 3);
        check("sat_ovf_c4", int'(ovf_s), 0);
        step(); in_s = 1'b0;
        check("sat_ovf_c5", int'(ovf_s), 1);
        check("sat_pend_c5", int'(pend_s), 3);
        repeat (25) step();
        check("sat_ovf_sticky", int'(ovf_s), 1);
        check("sat_pend_drained", int'(pend_s), 0);
        clr_s = 1'b1;
        step(); clr_s = 1'b0;
        check("sat_ovf_cleared", int'(ovf_s), 0);
        wait_idle();

        // Asynchronous reset mid-burst with pending = 5 during WAIT.
        b = cyc;
        in_m = 1'b1; exp_m.push_back(b + 1);
        repeat (6) step();
        in_m = 1'b0;
        check("midrst_pend_before", int'(pend_m), 5);
        check("midrst_busy_before", int'(busy_m), 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_pend", int'(pend_m), 0);
        check("midrst_busy", int'(busy_m), 0);
        check("midrst_out", int'(out_m), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) step();
        check("midrst_pend_after", int'(pend_m), 0);
        check("midrst_busy_after", int'(busy_m), 0);

        // Every queued pulse must have been seen.
        check("main_queue_left", exp_m.size(), 0);
        check("small_queue_left", exp_s.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
